// File: rtl/adder_checker.sv
// adder_checker: run-based checker for a 2-bit adder with carry-in.
// A run starts on 'start', checks N_VEC valid samples of {a,b,cin,sum,cout}
// against a golden 3-bit sum, and reports error count, pass and first failure.
// Optional build macro ADDER_CHECKER_CORE_EN adds a second (carry-in-less)
// core result comparison with its own sticky error flag.
module adder_checker #(
  parameter int N_VEC = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       vld,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  input  logic [1:0] sum,
  input  logic       cout,
`ifdef ADDER_CHECKER_CORE_EN
  input  logic [1:0] core_sum,
  input  logic       core_cout,
  output logic       core_err,
`endif
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] vec_cnt,
  output logic [5:0] err_cnt,
  output logic       fail_vld,
  output logic [4:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] LAST_VEC = 6'(N_VEC - 1);

  state_t     state;
  logic [1:0] rst_pipe;
  logic       armed;
  logic       go;
  logic [2:0] golden;
  logic       main_mis;
  logic       core_mis;
  logic       mis;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  // Reset release is retimed to clk; assertion stays asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign armed = rst_pipe[1];
  assign go    = start & armed;

  // Golden result and per-sample mismatch detection.
  always_comb begin
    golden   = {1'b0, a} + {1'b0, b} + {2'b00, cin};
    main_mis = ({cout, sum} != golden);
    core_mis = 1'b0;
`ifdef ADDER_CHECKER_CORE_EN
    core_mis = ({core_cout, core_sum} != ({1'b0, a} + {1'b0, b}));
`endif
    mis      = main_mis | core_mis;
  end

  // Run control FSM with registered status, counters and failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      vec_cnt  <= '0;
      err_cnt  <= '0;
      fail_vld <= 1'b0;
      fail_vec <= '0;
`ifdef ADDER_CHECKER_CORE_EN
      core_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          // vld is ignored here; a coincident sample is never checked.
          if (go) begin
            state    <= RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            vec_cnt  <= '0;
            err_cnt  <= '0;
            fail_vld <= 1'b0;
            fail_vec <= '0;
`ifdef ADDER_CHECKER_CORE_EN
            core_err <= 1'b0;
`endif
          end
        end
        RUN: begin
          // start is ignored while running.
          if (vld) begin
            vec_cnt <= sat_inc(vec_cnt);
            if (mis) begin
              err_cnt <= sat_inc(err_cnt);
              if (!fail_vld) begin
                fail_vld <= 1'b1;
                fail_vec <= {a, b, cin};
              end
            end
`ifdef ADDER_CHECKER_CORE_EN
            if (core_mis) core_err <= 1'b1;
`endif
            if (vec_cnt == LAST_VEC) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign pass = done & (err_cnt == 6'd0);

endmodule
